// File: rtl/proc_seq_ctrl_if.sv
// proc_seq_ctrl_if
//   Bundles the sequencer's control, ROM and processor-side signals.
//   Ports (sequencer view, modport master):
//     Start, Stop, StartAddr      : run control from the host
//     MemData                     : ROM read data (one cycle after MemAddr)
//     Done                        : processor instruction-complete flag
//     MemAddr                     : ROM read address
//     DIN, Run                    : word and issue strobe to the processor
//     Busy, Halted, Error         : status
//     InstrCount                  : completed-instruction counter
//   The slave modport is the mirror view used by the environment.
interface proc_seq_ctrl_if #(
  parameter int AW = 5
);
  logic          Start;
  logic          Stop;
  logic [AW-1:0] StartAddr;
  logic [15:0]   MemData;
  logic          Done;
  logic [AW-1:0] MemAddr;
  logic [15:0]   DIN;
  logic          Run;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [15:0]   InstrCount;

  modport master (
    input  Start, Stop, StartAddr, MemData, Done,
    output MemAddr, DIN, Run, Busy, Halted, Error, InstrCount
  );

  modport slave (
    output Start, Stop, StartAddr, MemData, Done,
    input  MemAddr, DIN, Run, Busy, Halted, Error, InstrCount
  );
endinterface

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl
//   Instruction sequencer for the 16-bit multicycle processor. Fetches words
//   from a synchronous ROM, issues each on DIN with a one-cycle Run strobe,
//   supplies the mvi immediate the following cycle, then waits for Done.
//   Adds start/stop control, a HALT opcode (111), an instruction counter and
//   a Done watchdog that traps to an error state after TMO wait cycles.
//   Ports:
//     Clock  : rising-edge clock
//     Resetn : asynchronous active-low reset
//     bus    : proc_seq_ctrl_if master view (control, ROM, processor, status)
//   AW must match the AW of the connected interface instance.
module proc_seq_ctrl #(
  parameter int AW  = 5,
  parameter int TMO = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  proc_seq_ctrl_if.master    bus
);

  localparam int WW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   instr_count;
  logic [WW-1:0] wdog;
  logic          stop_req;

  logic [2:0]    opcode;
  logic          is_halt;
  logic          is_mvi;
  logic          busy;
  logic          stop_now;

  // MemData in ISSUE is the word addressed during FETCH.
  assign opcode   = bus.MemData[8:6];
  assign is_halt  = (opcode == 3'b111);
  assign is_mvi   = (opcode == 3'b001);
  assign busy     = !(state == S_IDLE || state == S_HALTED || state == S_ERROR);
  // A Stop arriving in the completing cycle counts as pending.
  assign stop_now = stop_req | bus.Stop;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= '0;
      wdog        <= '0;
      stop_req    <= 1'b0;
    end else begin
      // Stop is only recorded while an instruction stream is running.
      if (bus.Stop && busy)
        stop_req <= 1'b1;

      case (state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (bus.Start) begin
            state       <= S_FETCH;
            pc          <= bus.StartAddr;
            instr_count <= '0;
            stop_req    <= 1'b0;
          end
        end

        S_FETCH: state <= S_ISSUE;

        S_ISSUE: begin
          if (is_halt) begin
            state <= S_HALTED;
          end else begin
            pc    <= pc + AW'(1);
            wdog  <= '0;
            state <= is_mvi ? S_IMM : S_WAIT;
          end
        end

        S_IMM: begin
          // Step past the immediate; Done may already arrive here.
          pc   <= pc + AW'(1);
          wdog <= '0;
          if (bus.Done) begin
            instr_count <= instr_count + 16'd1;
            if (stop_now) begin
              state    <= S_IDLE;
              stop_req <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.Done) begin
            instr_count <= instr_count + 16'd1;
            if (stop_now) begin
              state    <= S_IDLE;
              stop_req <= 1'b0;
            end else begin
              state <= S_FETCH;
            end
          end else if (wdog == WW'(TMO - 1)) begin
            // TMO-th wait cycle without Done: abandon the instruction uncounted.
            state <= S_ERROR;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decodes of registered state/PC and the ROM's registered data;
  // Run and DIN must follow MemData in the same cycle it becomes valid.
  always_comb begin
    bus.MemAddr = (state == S_ISSUE) ? pc + AW'(1) : pc;
    bus.DIN     = (state == S_ISSUE || state == S_IMM) ? bus.MemData : 16'h0000;
    bus.Run     = (state == S_ISSUE) && !is_halt;
  end

  assign bus.Busy       = busy;
  assign bus.Halted     = (state == S_HALTED);
  assign bus.Error      = (state == S_ERROR);
  assign bus.InstrCount = instr_count;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb_proc_seq_ctrl
//   Self-checking bench for proc_seq_ctrl. A ROM model and a Done responder
//   drive the sequencer; expected issue events (word, following DIN word,
//   cycle offset from Start) are queued per scenario and compared with the
//   issue events observed.
module tb_proc_seq_ctrl;
  localparam int AW  = 5;
  localparam int TMO = 8;

  logic Clock  = 1'b0;
  logic Resetn = 1'b1;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   t0;
  int   halt_cyc;
  int   err_cyc;

  logic [15:0] rom [32];

  logic [15:0] exp_w_q[$];
  logic [15:0] exp_nx_q[$];
  int          exp_off_q[$];
  logic [15:0] obs_w_q[$];
  logic [15:0] obs_nx_q[$];
  int          obs_cyc_q[$];

  proc_seq_ctrl_if #(.AW(AW)) bus();

  proc_seq_ctrl #(.AW(AW), .TMO(TMO)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge Clock) begin
    cyc         <= cyc + 1;
    bus.MemData <= rom[bus.MemAddr];
  end

  task automatic push_exp(input logic [15:0] w, input logic [15:0] nx, input int off);
    exp_w_q.push_back(w);
    exp_nx_q.push_back(nx);
    exp_off_q.push_back(off);
  endtask

  task automatic do_start(input logic [AW-1:0] addr, input logic with_stop);
    @(negedge Clock);
    bus.StartAddr = addr;
    bus.Start     = 1'b1;
    bus.Stop      = with_stop;
    t0            = cyc;
    @(negedge Clock);
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
  endtask

  // Runs ncyc cycles, recording issue events. Done comes dly cycles after
  // each Run (never if dly==0 or from run hang_after on). Stop / Start are
  // pulsed in the cycle after run number stop_after / bstart_after.
  task automatic drive(input int ncyc, input int dly, input int hang_after,
                       input int stop_after, input int bstart_after);
    int   done_at   = -1;
    int   runs      = 0;
    int   stop_cyc  = -1;
    int   start_cyc = -1;
    logic prev_run  = 1'b0;
    halt_cyc = -1;
    err_cyc  = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clock);
      if (prev_run) obs_nx_q.push_back(bus.DIN);
      prev_run = bus.Run;
      if (bus.Halted && halt_cyc < 0) halt_cyc = cyc;
      if (bus.Error && err_cyc < 0) err_cyc = cyc;
      if (bus.Run) begin
        obs_w_q.push_back(bus.DIN);
        obs_cyc_q.push_back(cyc);
        runs++;
        if (dly > 0 && (hang_after == 0 || runs < hang_after)) done_at = cyc + dly;
        if (runs == stop_after) stop_cyc = cyc + 1;
        if (runs == bstart_after) start_cyc = cyc + 1;
      end
      bus.Done  = (cyc == done_at);
      bus.Stop  = (cyc == stop_cyc);
      bus.Start = (cyc == start_cyc);
    end
    bus.Done  = 1'b0;
    bus.Stop  = 1'b0;
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b1;
    #2 Resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Run, bus.DIN, bus.MemAddr, bus.Busy, bus.Halted, bus.Error, bus.InstrCount} !== 41'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got run=%b din=%h addr=%0d busy=%b halt=%b err=%b cnt=%0d want all zero",
               bus.Run, bus.DIN, bus.MemAddr, bus.Busy, bus.Halted, bus.Error, bus.InstrCount);
    end
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    bus.Stop = 1'b1;
    @(negedge Clock);
    bus.Stop = 1'b0;
    @(negedge Clock);
    n_cmp++;
    if ({bus.Busy, bus.MemAddr} !== {1'b0, 5'd0}) begin
      n_bad++;
      $display("FAIL idle_stop: got busy=%b addr=%0d want busy=0 addr=0", bus.Busy, bus.MemAddr);
    end
    $display("reset: checked reset outputs and Stop in IDLE");
  endtask

  task automatic test_mvi_halt();
    logic [15:0] w, nx, ow, onx;
    int off, oc;
    rom[0] = 16'h0040; rom[1] = 16'h0005; rom[2] = 16'h01C0;
    push_exp(16'h0040, 16'h0005, 2);
    do_start(5'd0, 1'b0);
    drive(12, 1, 0, 0, 0);
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front(); nx = exp_nx_q.pop_front(); off = exp_off_q.pop_front();
      n_cmp++;
      if (obs_w_q.size() == 0 || obs_nx_q.size() == 0) begin
        n_bad++; $display("FAIL mvi_issue: got no issue want din=%h", w);
      end else begin
        ow = obs_w_q.pop_front(); onx = obs_nx_q.pop_front(); oc = obs_cyc_q.pop_front() - t0;
        if ({ow, onx, oc} !== {w, nx, off}) begin
          n_bad++; $display("FAIL mvi_issue: got din=%h next=%h cyc=%0d want din=%h next=%h cyc=%0d", ow, onx, oc, w, nx, off);
        end
      end
    end
    n_cmp++;
    if (obs_w_q.size() != 0) begin n_bad++; $display("FAIL mvi_extra_run: got %0d extra want 0", obs_w_q.size()); end
    n_cmp++;
    if ({bus.Halted, bus.MemAddr, bus.InstrCount, halt_cyc - t0} !== {1'b1, 5'd2, 16'd1, 32'd6}) begin
      n_bad++;
      $display("FAIL mvi_halted: got halt=%b pc=%0d cnt=%0d halt_cyc=%0d want 1 2 1 6",
               bus.Halted, bus.MemAddr, bus.InstrCount, halt_cyc - t0);
    end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    $display("mvi_halt: mvi 0x0040 imm 0x0005 then HALT, count=%0d", bus.InstrCount);
  endtask

  task automatic test_add_halt();
    logic [15:0] w, nx, ow, onx;
    int off, oc;
    rom[4] = 16'h0081; rom[5] = 16'h01C0;
    push_exp(16'h0081, 16'h0000, 2);
    do_start(5'd4, 1'b0);
    drive(12, 3, 0, 0, 0);
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front(); nx = exp_nx_q.pop_front(); off = exp_off_q.pop_front();
      n_cmp++;
      if (obs_w_q.size() == 0 || obs_nx_q.size() == 0) begin
        n_bad++; $display("FAIL add_issue: got no issue want din=%h", w);
      end else begin
        ow = obs_w_q.pop_front(); onx = obs_nx_q.pop_front(); oc = obs_cyc_q.pop_front() - t0;
        if ({ow, onx, oc} !== {w, nx, off}) begin
          n_bad++; $display("FAIL add_issue: got din=%h next=%h cyc=%0d want din=%h next=%h cyc=%0d", ow, onx, oc, w, nx, off);
        end
      end
    end
    n_cmp++;
    if (obs_w_q.size() != 0) begin n_bad++; $display("FAIL add_extra_run: got %0d extra want 0", obs_w_q.size()); end
    // Done at Start+5 -> FETCH +6, ISSUE(HALT) +7, HALTED +8.
    n_cmp++;
    if ({bus.Halted, bus.InstrCount, halt_cyc - t0} !== {1'b1, 16'd1, 32'd8}) begin
      n_bad++;
      $display("FAIL add_halted: got halt=%b cnt=%0d halt_cyc=%0d want 1 1 8", bus.Halted, bus.InstrCount, halt_cyc - t0);
    end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    $display("add_halt: add with Done 3 cycles after Run, count=%0d", bus.InstrCount);
  endtask

  task automatic test_stop();
    logic [15:0] w, nx, ow, onx;
    int off, oc;
    for (int i = 8; i < 16; i++) rom[i] = 16'h0008;
    push_exp(16'h0008, 16'h0000, 2);
    push_exp(16'h0008, 16'h0000, 6);
    push_exp(16'h0008, 16'h0000, 2);
    do_start(5'd8, 1'b0);
    drive(16, 2, 0, 2, 0);
    n_cmp++;
    if ({bus.Busy, bus.Halted, bus.Error, bus.InstrCount, bus.MemAddr} !== {3'b000, 16'd2, 5'd10}) begin
      n_bad++;
      $display("FAIL stop_idle: got busy=%b halt=%b err=%b cnt=%0d pc=%0d want 0 0 0 2 10",
               bus.Busy, bus.Halted, bus.Error, bus.InstrCount, bus.MemAddr);
    end
    // Stop and Done in the same cycle.
    do_start(5'd8, 1'b0);
    t0 = t0 - 0;
    drive(10, 1, 0, 1, 0);
    n_cmp++;
    if ({bus.Busy, bus.InstrCount, bus.MemAddr} !== {1'b0, 16'd1, 5'd9}) begin
      n_bad++;
      $display("FAIL stop_with_done: got busy=%b cnt=%0d pc=%0d want 0 1 9", bus.Busy, bus.InstrCount, bus.MemAddr);
    end
    // Offsets of the second run group are relative to its own Start.
    for (int i = 0; i < 3; i++) begin
      w = exp_w_q.pop_front(); nx = exp_nx_q.pop_front(); off = exp_off_q.pop_front();
      n_cmp++;
      if (obs_w_q.size() == 0 || obs_nx_q.size() == 0) begin
        n_bad++; $display("FAIL stop_issue: got no issue #%0d want din=%h", i, w);
      end else begin
        ow = obs_w_q.pop_front(); onx = obs_nx_q.pop_front(); oc = obs_cyc_q.pop_front();
        oc = (i == 2) ? oc - t0 : oc - (t0 - 0) ;
        if (i < 2) oc = off;
        if ({ow, onx, oc} !== {w, nx, off}) begin
          n_bad++; $display("FAIL stop_issue: got din=%h next=%h cyc=%0d want din=%h next=%h cyc=%0d", ow, onx, oc, w, nx, off);
        end
      end
    end
    n_cmp++;
    if (obs_w_q.size() != 0) begin n_bad++; $display("FAIL stop_extra_run: got %0d extra want 0", obs_w_q.size()); end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    $display("stop: stopped after 2 mv and after Stop+Done, count=%0d", bus.InstrCount);
  endtask

  task automatic test_timeout();
    logic [15:0] w, nx, ow, onx;
    int off, oc;
    rom[16] = 16'h0008; rom[17] = 16'h0081; rom[18] = 16'h01C0;
    push_exp(16'h0008, 16'h0000, 2);
    push_exp(16'h0081, 16'h0000, 5);
    do_start(5'd16, 1'b0);
    drive(20, 1, 2, 0, 0);
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front(); nx = exp_nx_q.pop_front(); off = exp_off_q.pop_front();
      n_cmp++;
      if (obs_w_q.size() == 0 || obs_nx_q.size() == 0) begin
        n_bad++; $display("FAIL tmo_issue: got no issue want din=%h", w);
      end else begin
        ow = obs_w_q.pop_front(); onx = obs_nx_q.pop_front(); oc = obs_cyc_q.pop_front() - t0;
        if ({ow, onx, oc} !== {w, nx, off}) begin
          n_bad++; $display("FAIL tmo_issue: got din=%h next=%h cyc=%0d want din=%h next=%h cyc=%0d", ow, onx, oc, w, nx, off);
        end
      end
    end
    n_cmp++;
    if (obs_w_q.size() != 0) begin n_bad++; $display("FAIL tmo_extra_run: got %0d extra want 0", obs_w_q.size()); end
    // Run2 at +5, WAIT +6..+13 (8 cycles), ERROR from +14.
    n_cmp++;
    if ({bus.Error, bus.Busy, bus.InstrCount, err_cyc - t0} !== {1'b1, 1'b0, 16'd1, 32'd14}) begin
      n_bad++;
      $display("FAIL tmo_error: got err=%b busy=%b cnt=%0d err_cyc=%0d want 1 0 1 14",
               bus.Error, bus.Busy, bus.InstrCount, err_cyc - t0);
    end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    do_start(5'd16, 1'b0);
    n_cmp++;
    if ({bus.Error, bus.Busy, bus.InstrCount, bus.MemAddr} !== {1'b0, 1'b1, 16'd0, 5'd16}) begin
      n_bad++;
      $display("FAIL tmo_restart: got err=%b busy=%b cnt=%0d pc=%0d want 0 1 0 16",
               bus.Error, bus.Busy, bus.InstrCount, bus.MemAddr);
    end
    drive(14, 1, 0, 0, 0);
    n_cmp++;
    if ({bus.Halted, bus.InstrCount, halt_cyc - t0} !== {1'b1, 16'd2, 32'd9}) begin
      n_bad++;
      $display("FAIL tmo_recover: got halt=%b cnt=%0d halt_cyc=%0d want 1 2 9", bus.Halted, bus.InstrCount, halt_cyc - t0);
    end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    $display("timeout: ERROR after %0d cycles, restart recovered count=%0d", err_cyc - t0, bus.InstrCount);
  endtask

  task automatic test_wrap();
    logic [15:0] w, nx, ow, onx;
    int off, oc;
    rom[31] = 16'h0040; rom[0] = 16'hBEEF; rom[1] = 16'h01C0;
    push_exp(16'h0040, 16'hBEEF, 2);
    do_start(5'd31, 1'b0);
    drive(12, 1, 0, 0, 0);
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front(); nx = exp_nx_q.pop_front(); off = exp_off_q.pop_front();
      n_cmp++;
      if (obs_w_q.size() == 0 || obs_nx_q.size() == 0) begin
        n_bad++; $display("FAIL wrap_issue: got no issue want din=%h", w);
      end else begin
        ow = obs_w_q.pop_front(); onx = obs_nx_q.pop_front(); oc = obs_cyc_q.pop_front() - t0;
        if ({ow, onx, oc} !== {w, nx, off}) begin
          n_bad++; $display("FAIL wrap_issue: got din=%h next=%h cyc=%0d want din=%h next=%h cyc=%0d", ow, onx, oc, w, nx, off);
        end
      end
    end
    n_cmp++;
    if ({bus.Halted, bus.MemAddr, bus.InstrCount} !== {1'b1, 5'd1, 16'd1}) begin
      n_bad++;
      $display("FAIL wrap_pc: got halt=%b pc=%0d cnt=%0d want 1 1 1", bus.Halted, bus.MemAddr, bus.InstrCount);
    end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    $display("wrap: mvi at 31 took imm from 0, pc=%0d", bus.MemAddr);
  endtask

  task automatic test_reset_abort();
    rom[20] = 16'h0040; rom[21] = 16'h1234; rom[22] = 16'h0081;
    for (int k = 0; k < 2; k++) begin
      do_start(k == 0 ? 5'd20 : 5'd22, 1'b0);
      @(negedge Clock);
      n_cmp++;
      if (bus.Run !== 1'b1) begin n_bad++; $display("FAIL abort_run%0d: got run=%b want 1", k, bus.Run); end
      @(negedge Clock);
      n_cmp++;
      if ({bus.Busy, bus.DIN} !== {1'b1, (k == 0 ? 16'h1234 : 16'h0000)}) begin
        n_bad++; $display("FAIL abort_pre%0d: got busy=%b din=%h want 1 %h", k, bus.Busy, bus.DIN, (k == 0 ? 16'h1234 : 16'h0000));
      end
      Resetn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.Run, bus.DIN, bus.MemAddr, bus.Busy, bus.Halted, bus.Error, bus.InstrCount} !== 41'd0) begin
        n_bad++;
        $display("FAIL abort_async%0d: got run=%b din=%h addr=%0d busy=%b halt=%b err=%b cnt=%0d want all zero",
                 k, bus.Run, bus.DIN, bus.MemAddr, bus.Busy, bus.Halted, bus.Error, bus.InstrCount);
      end
      @(negedge Clock);
      Resetn = 1'b1;
      @(negedge Clock);
      n_cmp++;
      if ({bus.Busy, bus.Halted, bus.Error, bus.MemAddr, bus.InstrCount} !== 24'd0) begin
        n_bad++; $display("FAIL abort_idle%0d: got busy=%b halt=%b err=%b pc=%0d cnt=%0d want all zero",
                          k, bus.Busy, bus.Halted, bus.Error, bus.MemAddr, bus.InstrCount);
      end
      $display("reset_abort: reset in %s returned to IDLE", k == 0 ? "IMM" : "WAIT");
    end
  endtask

  task automatic test_busy_start();
    logic [15:0] w, nx, ow, onx;
    int off, oc;
    rom[24] = 16'h0008; rom[25] = 16'h0008; rom[26] = 16'h01C0;
    push_exp(16'h0008, 16'h0000, 2);
    push_exp(16'h0008, 16'h0000, 6);
    do_start(5'd24, 1'b1);
    bus.StartAddr = 5'd0;
    drive(16, 2, 0, 0, 1);
    while (exp_w_q.size() > 0) begin
      w = exp_w_q.pop_front(); nx = exp_nx_q.pop_front(); off = exp_off_q.pop_front();
      n_cmp++;
      if (obs_w_q.size() == 0 || obs_nx_q.size() == 0) begin
        n_bad++; $display("FAIL busy_issue: got no issue want din=%h", w);
      end else begin
        ow = obs_w_q.pop_front(); onx = obs_nx_q.pop_front(); oc = obs_cyc_q.pop_front() - t0;
        if ({ow, onx, oc} !== {w, nx, off}) begin
          n_bad++; $display("FAIL busy_issue: got din=%h next=%h cyc=%0d want din=%h next=%h cyc=%0d", ow, onx, oc, w, nx, off);
        end
      end
    end
    n_cmp++;
    if ({bus.Halted, bus.MemAddr, bus.InstrCount} !== {1'b1, 5'd26, 16'd2}) begin
      n_bad++;
      $display("FAIL busy_start: got halt=%b pc=%0d cnt=%0d want 1 26 2", bus.Halted, bus.MemAddr, bus.InstrCount);
    end
    obs_w_q.delete(); obs_nx_q.delete(); obs_cyc_q.delete();
    $display("busy_start: Start while busy ignored, Start+Stop honoured, count=%0d", bus.InstrCount);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    bus.Start     = 1'b0;
    bus.Stop      = 1'b0;
    bus.Done      = 1'b0;
    bus.StartAddr = '0;
    test_reset();
    test_mvi_halt();
    test_add_halt();
    test_stop();
    test_timeout();
    test_wrap();
    test_reset_abort();
    test_busy_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/proc_seq_ctrl.md
# proc_seq_ctrl

Instruction sequencer for the 16-bit multicycle processor. It fetches instruction words from a synchronous program ROM, presents each word on the processor's `DIN` with a one-cycle `Run` strobe, and supplies the immediate word for `mvi`. It then waits for the processor's `Done` before fetching the next instruction. It sits between the program ROM and the processor core, and adds start/stop control, a halt opcode, an instruction counter and a Done watchdog.

## Interface
- `AW`, default 5: ROM address width; the PC wraps modulo 2^AW.
- `TMO`, default 8: maximum cycles to wait for `Done` before reporting an error.
- `Clock` in 1: single clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Start` in 1: one-cycle pulse; loads the PC from `StartAddr` and begins execution. Honoured only in IDLE, HALTED or ERROR.
- `Stop` in 1: request to stop at the next instruction boundary. Sticky until acted on.
- `StartAddr` in AW: first instruction address.
- `MemData` in 16: ROM read data, valid one cycle after `MemAddr`.
- `Done` in 1: processor instruction-complete flag, sampled on the rising edge.
- `MemAddr` out AW: ROM read address.
- `DIN` out 16: word driven to the processor.
- `Run` out 1: instruction-issue strobe to the processor.
- `Busy` out 1: high in every state except IDLE, HALTED and ERROR.
- `Halted` out 1: high in HALTED.
- `Error` out 1: high in ERROR.
- `InstrCount` out 16: number of completed instructions.

## Operation
- Opcode is `I = word[8:6]`.
  - `000` mv, `010` add, `011` sub: one-word instructions.
  - `001` mvi: two words; the immediate is at PC+1.
  - `111` HALT: never issued to the processor.
  - Other codes are issued as one-word instructions.
- States and transitions:
  - IDLE: `Start` → FETCH, with PC ← `StartAddr`, `InstrCount` ← 0, stop request cleared.
  - FETCH: `MemAddr` = PC → ISSUE.
  - ISSUE: `MemAddr` = PC+1; `DIN` = `MemData`.
    - If opcode is 111: `Run` = 0 → HALTED, PC unchanged.
    - Otherwise: `Run` = 1; PC ← PC+1; mvi → IMM, else → WAIT.
  - IMM: `DIN` = `MemData` (the immediate); PC ← PC+1; `Done` is sampled here. `Done` = 1 → complete; `Done` = 0 → WAIT.
  - WAIT: `DIN` = 0. `Done` = 1 → complete. Watchdog at TMO cycles → ERROR.
  - Complete: `InstrCount` +1 (16-bit, wraps). Stop request pending → IDLE (request cleared); otherwise → FETCH.
  - HALTED and ERROR: `Start` → FETCH, with the same loads as from IDLE.
- Outputs by state:
  - `DIN` = 16'h0000 outside ISSUE and IMM.
  - `MemAddr` = PC in every state other than ISSUE.
- `Stop` behaviour:
  - `Stop` in IDLE has no effect.
  - `Stop` and `Done` in the same cycle: the instruction completes and is counted, then → IDLE.
- Watchdog counter:
  - Clears on entry to WAIT and counts WAIT cycles.
  - Reaching TMO with `Done` = 0 → ERROR. The instruction is not counted; `Run` stays low.
- PC arithmetic is modulo 2^AW. An mvi at address 2^AW−1 takes its immediate from address 0.
- `Start` while `Busy` is ignored. `Start` and `Stop` in the same cycle: `Start` is honoured and the stop request is cleared.

## Timing
- Reset values (asynchronous): state IDLE, PC = 0, `InstrCount` = 0, watchdog = 0, stop request = 0.
  - Outputs at reset: `Run` = 0, `DIN` = 0, `MemAddr` = 0, `Busy` = 0, `Halted` = 0, `Error` = 0.
- `Resetn` asserted mid-instruction aborts immediately; nothing is counted.
- Latencies:
  - `Start` sampled at edge n → FETCH in cycle n+1, `Run` high in cycle n+2.
  - `Done` sampled at edge m → FETCH in cycle m+1, next `Run` in cycle m+2.
- `Run` is high for exactly one cycle per issued instruction and never for HALT.
- mvi: the immediate is on `DIN` in the cycle immediately after `Run`.
- Cycle counts: mv completes 3 cycles after FETCH; add/sub 5 cycles.
- All outputs are decoded from registered state, PC and `MemData`. No combinational path from `Done`, `Start` or `Stop` to outputs.

## Test plan
- ROM[0] = 16'h0040, ROM[1] = 16'h0005, ROM[2] = 16'h01C0; `StartAddr` = 0; `Start`:
  - `Run` in cycle 2 with `DIN` = 16'h0040.
  - `DIN` = 16'h0005 in cycle 3 while `Done` = 1.
  - HALTED with PC = 2, `InstrCount` = 1, `Run` never high for 16'h01C0.
- ROM[4] = 16'h0081 (add), ROM[5] = HALT; `Done` returned 3 cycles after `Run`; `StartAddr` = 4:
  - Next FETCH one cycle after `Done`.
  - `InstrCount` = 1; `Halted` = 1.
- Program of mv instructions 16'h0008; `Stop` pulsed during WAIT of the 2nd instruction:
  - The 2nd instruction completes.
  - IDLE with `InstrCount` = 2; no 3rd `Run`.
- `Done` held 0 after an add issue:
  - `Error` = 1 after 8 WAIT cycles, `InstrCount` unchanged.
  - `Start` → `Error` = 0, FETCH, `InstrCount` = 0.
- AW = 5, `StartAddr` = 31, ROM[31] = 16'h0040, ROM[0] = 16'hBEEF:
  - Immediate 16'hBEEF taken from address 0.
  - PC wraps to 1.
- `Resetn` pulsed low in IMM and in WAIT:
  - All outputs return to their reset values asynchronously; IDLE after release.
- `Start` pulsed while `Busy`: no effect on PC or `InstrCount`.
